// File: rtl/bpm_tracker.sv
// bpm_tracker: baton tempo estimator in the camera clock domain.
// Counts rising edges of change_in over a WINDOW_S-second window, converts
// the count to beats per minute (hits * 60/WINDOW_S), clamps it to
// [BPM_MIN, BPM_MAX] and publishes it on bpm_out. Also offers a manual
// override tempo and a default tempo, and drives a countdown LED bar.
// Optional feature macro: BPM_EMA_EN (when defined, a measured result is
// averaged with the previous tempo instead of replacing it).
// Ports:
//   clk_camera_in  - clock
//   rst_n_in       - asynchronous active-low reset
//   mode_in        - 0 idle, 1 baton measure, 2 override, 3 default
//   change_in      - baton hit level from the change detector
//   bpm_in         - manual tempo for override mode
//   bpm_out        - current tempo
//   bpm_valid_out  - one-cycle pulse after bpm_out changes value
//   busy_out       - high while a measurement window is running
//   abort_out      - one-cycle pulse when a measurement is aborted
//   led_out        - countdown bar, shifts right once per tick
module bpm_tracker #(
  parameter int unsigned CLK_HZ      = 200_000_000,
  parameter int unsigned WINDOW_S    = 15,
  parameter int unsigned LED_N       = 15,
  parameter int unsigned BPM_W       = 9,
  parameter int unsigned BPM_MIN     = 40,
  parameter int unsigned BPM_MAX     = 300,
  parameter int unsigned BPM_DEFAULT = 120,
  parameter int unsigned HOLDOFF_CYC = 0
) (
  input  logic             clk_camera_in,
  input  logic             rst_n_in,
  input  logic [1:0]       mode_in,
  input  logic             change_in,
  input  logic [BPM_W-1:0] bpm_in,
  output logic [BPM_W-1:0] bpm_out,
  output logic             bpm_valid_out,
  output logic             busy_out,
  output logic             abort_out,
  output logic [LED_N-1:0] led_out
);

  localparam int unsigned      K          = 60 / WINDOW_S;
  localparam longint unsigned  WINDOW_CYC = 64'(CLK_HZ) * 64'(WINDOW_S);
  localparam longint unsigned  TICK_CYC   = WINDOW_CYC / 64'(LED_N);
  localparam int unsigned      CYC_W      = (WINDOW_CYC > 64'd1) ? $clog2(WINDOW_CYC) : 1;
  localparam int unsigned      TICK_W     = (TICK_CYC > 64'd1) ? $clog2(TICK_CYC) : 1;
  localparam int unsigned      HO_W       = (HOLDOFF_CYC > 0) ? $clog2(HOLDOFF_CYC + 1) : 1;
  localparam int unsigned      HIT_W      = 16;
  localparam int unsigned      RAW_W      = HIT_W + $clog2(K + 1);
  localparam int unsigned      CL_W       = (RAW_W > BPM_W) ? RAW_W : BPM_W;
  localparam int unsigned      SUM_W      = BPM_W + 1;

  localparam logic [1:0] MODE_BATON    = 2'd1;
  localparam logic [1:0] MODE_OVERRIDE = 2'd2;
  localparam logic [1:0] MODE_DEFAULT  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_RESULT} state_t;

  state_t             state_q;
  logic [1:0]         prev_mode_q;
  logic               change_q;
  logic [HO_W-1:0]    ho_q;
  logic [HIT_W-1:0]   hits_q;
  logic [CYC_W-1:0]   cyc_q;
  logic [TICK_W-1:0]  tick_q;
  logic [BPM_W-1:0]   bpm_q;
  logic [BPM_W-1:0]   bpm_prev_q;
  logic               valid_q;
  logic               busy_q;
  logic               abort_q;
  logic [LED_N-1:0]   led_q;

  logic               count_c;
  logic [RAW_W-1:0]   raw_c;
  logic [BPM_W-1:0]   meas_c;
  logic [BPM_W-1:0]   ovr_c;
  logic [BPM_W-1:0]   res_c;

  // Clamp at full width so large counts never wrap into the legal range.
  function automatic logic [BPM_W-1:0] clamp(input logic [CL_W-1:0] v);
    if (v < CL_W'(BPM_MIN)) return BPM_W'(BPM_MIN);
    if (v > CL_W'(BPM_MAX)) return BPM_W'(BPM_MAX);
    return v[BPM_W-1:0];
  endfunction

  // Hit qualification: rising edge, outside holdoff, inside a live window
  // (a same-cycle abort discards the hit).
  always_comb begin
    count_c = 1'b0;
    if (state_q == S_MEASURE && mode_in == MODE_BATON &&
        change_in && !change_q && ho_q == '0) begin
      count_c = 1'b1;
    end
  end

  // Tempo datapath: measured, override and result-write values.
  always_comb begin
    raw_c  = RAW_W'(hits_q) * RAW_W'(K);
    meas_c = clamp(CL_W'(raw_c));
    ovr_c  = clamp(CL_W'(bpm_in));
`ifdef BPM_EMA_EN
    begin
      logic [SUM_W-1:0] sum;
      sum   = SUM_W'(bpm_q) + SUM_W'(meas_c) + SUM_W'(1);
      res_c = sum[SUM_W-1:1];
    end
`else
    res_c  = meas_c;
`endif
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk_camera_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= S_IDLE;
      prev_mode_q <= 2'd0;
      change_q    <= 1'b0;
      ho_q        <= '0;
      hits_q      <= '0;
      cyc_q       <= '0;
      tick_q      <= '0;
      bpm_q       <= BPM_W'(BPM_DEFAULT);
      bpm_prev_q  <= BPM_W'(BPM_DEFAULT);
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      abort_q     <= 1'b0;
      led_q       <= '0;
    end else begin
      change_q    <= change_in;
      prev_mode_q <= mode_in;
      abort_q     <= 1'b0;
      // bpm_q only moves on writes, so a one-cycle-delayed compare flags changed writes.
      bpm_prev_q  <= bpm_q;
      valid_q     <= (bpm_q != bpm_prev_q);

      if (count_c) begin
        ho_q <= HO_W'(HOLDOFF_CYC);
      end else if (ho_q != '0) begin
        ho_q <= ho_q - HO_W'(1);
      end

      case (state_q)
        S_IDLE: begin
          busy_q <= 1'b0;
          if (mode_in != MODE_BATON) led_q <= '0;
          case (mode_in)
            MODE_OVERRIDE: bpm_q <= ovr_c;
            MODE_DEFAULT:  bpm_q <= BPM_W'(BPM_DEFAULT);
            MODE_BATON: begin
              // Only a fresh entry into baton mode starts a window.
              if (prev_mode_q != MODE_BATON) begin
                state_q <= S_MEASURE;
                hits_q  <= '0;
                cyc_q   <= '0;
                tick_q  <= '0;
                led_q   <= '1;
                busy_q  <= 1'b1;
              end
            end
            default: ;
          endcase
        end

        S_MEASURE: begin
          if (mode_in != MODE_BATON) begin
            state_q <= S_IDLE;
            led_q   <= '0;
            abort_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            if (count_c && hits_q != 16'hFFFF) hits_q <= hits_q + HIT_W'(1);
            if (tick_q == TICK_W'(TICK_CYC - 64'd1)) begin
              tick_q <= '0;
              led_q  <= led_q >> 1;
            end else begin
              tick_q <= tick_q + TICK_W'(1);
            end
            if (cyc_q == CYC_W'(WINDOW_CYC - 64'd1)) begin
              state_q <= S_RESULT;
              busy_q  <= 1'b0;
            end else begin
              cyc_q <= cyc_q + CYC_W'(1);
            end
          end
        end

        S_RESULT: begin
          bpm_q   <= res_c;
          led_q   <= '1;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bpm_out       = bpm_q;
  assign bpm_valid_out = valid_q;
  assign busy_out      = busy_q;
  assign abort_out     = abort_q;
  assign led_out       = led_q;

endmodule
